// File: rtl/line_burst_adapter_pkg.sv
// Shared cache datapath types: line/beat geometry and the burst adapter state encoding.
package cache_types;
  localparam int unsigned LINE_WIDTH = 256;
  localparam int unsigned BEAT_WIDTH = 64;
  localparam int unsigned BEATS      = LINE_WIDTH / BEAT_WIDTH;

  typedef logic [LINE_WIDTH-1:0] line_t;
  typedef logic [BEAT_WIDTH-1:0] beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } adapter_state_e;
endpackage

// File: rtl/line_burst_adapter_if.sv
// Cache-side line port plus memory-side burst port of the line burst adapter.
interface line_burst_adapter_if
  import cache_types::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic                  line_read_i;
  logic                  line_write_i;
  logic [ADDR_WIDTH-1:0] line_addr_i;
  line_t                 line_wdata_i;
  line_t                 line_rdata_o;
  logic                  line_resp_o;

  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_read_o;
  logic                  mem_write_o;
  beat_t                 mem_wdata_o;
  beat_t                 mem_rdata_i;
  logic                  mem_resp_i;

  // Adapter view.
  modport slave (
    input  line_read_i, line_write_i, line_addr_i, line_wdata_i,
    output line_rdata_o, line_resp_o,
    output mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o,
    input  mem_rdata_i, mem_resp_i
  );

  // Cache/memory side view.
  modport master (
    output line_read_i, line_write_i, line_addr_i, line_wdata_i,
    input  line_rdata_o, line_resp_o,
    input  mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o,
    output mem_rdata_i, mem_resp_i
  );
endinterface

// File: rtl/line_burst_adapter.sv
// Converts single-cycle cache line reads/writes into 4-beat memory bursts
// and returns a one-cycle completion pulse to the cache.
module line_burst_adapter
  import cache_types::*;
#(
  parameter int unsigned LINE_WIDTH = cache_types::LINE_WIDTH,
  parameter int unsigned BEAT_WIDTH = cache_types::BEAT_WIDTH,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  line_burst_adapter_if.slave bus
);
  localparam int unsigned BEATS_L = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CNT_W   = $clog2(BEATS_L);
  localparam int unsigned OFF_W   = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS_L - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

  adapter_state_e          state;
  logic [CNT_W-1:0]        cnt;
  logic [LINE_WIDTH-1:0]   wbuf;
  logic [LINE_WIDTH-1:0]   rbuf;
  logic [LINE_WIDTH-1:0]   rbuf_next;
  logic [LINE_WIDTH-1:0]   rdata_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    rd_q;
  logic                    wr_q;
  logic                    resp_q;

  // Fill buffer with the current beat merged in, so the final beat lands
  // in line_rdata_o on the same edge that raises line_resp_o.
  always_comb begin
    rbuf_next = rbuf;
    rbuf_next[cnt*BEAT_WIDTH +: BEAT_WIDTH] = bus.mem_rdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      wbuf    <= '0;
      rbuf    <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.line_write_i) begin
            addr_q <= bus.line_addr_i & ADDR_MASK;
            wbuf   <= bus.line_wdata_i;
            cnt    <= '0;
            wr_q   <= 1'b1;
            state  <= ST_WRITE;
          end else if (bus.line_read_i) begin
            addr_q <= bus.line_addr_i & ADDR_MASK;
            cnt    <= '0;
            rd_q   <= 1'b1;
            state  <= ST_READ;
          end
        end
        ST_READ: begin
          if (bus.mem_resp_i) begin
            rbuf <= rbuf_next;
            if (cnt == LAST_BEAT) begin
              rdata_q <= rbuf_next;
              rd_q    <= 1'b0;
              resp_q  <= 1'b1;
              cnt     <= '0;
              state   <= ST_DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_WRITE: begin
          if (bus.mem_resp_i) begin
            if (cnt == LAST_BEAT) begin
              wr_q   <= 1'b0;
              resp_q <= 1'b1;
              cnt    <= '0;
              state  <= ST_DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          resp_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_wdata_o = '0;
    if (state == ST_WRITE) bus.mem_wdata_o = wbuf[cnt*BEAT_WIDTH +: BEAT_WIDTH];
  end

  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_read_o   = rd_q;
  assign bus.mem_write_o  = wr_q;
  assign bus.line_resp_o  = resp_q;
  assign bus.line_rdata_o = rdata_q;
endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter: a stimulus process drives bursts and
// queues expected write beats / line responses; a negedge monitor checks them.
module tb_line_burst_adapter;
  import cache_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_burst_adapter_if #(.ADDR_WIDTH(32)) bus ();

  line_burst_adapter #(.LINE_WIDTH(256), .BEAT_WIDTH(64), .ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  beat_t wbeat_q[$];
  line_t resp_q[$];
  line_t cur_rdata = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: accepted write beats and completion pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_write_o && bus.mem_resp_i) begin
        if (wbeat_q.size() == 0) chk("unexpected_wbeat", 1, 0);
        else chk("mem_wdata", bus.mem_wdata_o, wbeat_q.pop_front());
      end
      if (bus.line_resp_o) begin
        if (resp_q.size() == 0) chk("unexpected_resp", 1, 0);
        else chk("line_rdata", bus.line_rdata_o, resp_q.pop_front());
        chk("mem_idle_at_resp", {bus.mem_read_o, bus.mem_write_o}, 0);
      end
    end
  end

  // pat: mem_resp_i per cycle from T+1, LSB first; 1s beyond bit 15.
  task automatic burst(input bit wr, input bit rd, input logic [31:0] addr,
                       input line_t wdata, input line_t rline,
                       input logic [15:0] pat, input int unsigned exp_lat,
                       input string name);
    int unsigned beats;
    int unsigned lat;
    int unsigned i;
    logic r;
    bus.line_write_i = wr;
    bus.line_read_i  = rd;
    bus.line_addr_i  = addr;
    bus.line_wdata_i = wdata;
    if (wr) begin
      for (int k = 0; k < 4; k++) wbeat_q.push_back(wdata[k*64 +: 64]);
    end else begin
      cur_rdata = rline;
    end
    resp_q.push_back(cur_rdata);
    @(posedge clk); #1;
    chk({name, "_addr"}, bus.mem_addr_o, {addr[31:5], 5'b0});
    chk({name, "_rw_start"}, {bus.mem_read_o, bus.mem_write_o}, wr ? 2'b01 : 2'b10);
    beats = 0; lat = 1; i = 0;
    while (beats < 4 && lat < 40) begin
      r = (i < 16) ? pat[i] : 1'b1;
      bus.mem_resp_i  = r;
      bus.mem_rdata_i = r ? rline[beats*64 +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
      @(posedge clk); #1;
      if (r) beats++;
      i++; lat++;
      if (beats < 4) chk({name, "_rw_held"}, {bus.mem_read_o, bus.mem_write_o}, wr ? 2'b01 : 2'b10);
    end
    bus.mem_resp_i = 1'b0;
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_resp_hi"}, bus.line_resp_o, 1'b1);
    @(posedge clk); #1;
    chk({name, "_resp_pulse"}, bus.line_resp_o, 1'b0);
    bus.line_read_i  = 1'b0;
    bus.line_write_i = 1'b0;
  endtask

  line_t l1, l2, l3, l4, wline;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.line_read_i  = 1'b0;
    bus.line_write_i = 1'b0;
    bus.line_addr_i  = '0;
    bus.line_wdata_i = '0;
    bus.mem_rdata_i  = '0;
    bus.mem_resp_i   = 1'b0;
    l1    = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    l2    = {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C, 64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A};
    l3    = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
    l4    = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003, 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
    wline = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {bus.mem_read_o, bus.mem_write_o, bus.line_resp_o}, 0);
    chk("rst_addr", bus.mem_addr_o, 0);
    chk("rst_wdata", bus.mem_wdata_o, 0);
    chk("rst_rdata", bus.line_rdata_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    burst(0, 1, 32'h0000_1234, '0, l1, 16'hFFFF, 5, "rd0");
    burst(1, 0, 32'h8000_00FF, l2, '0, 16'hFFFF, 5, "wr0");
    chk("rdata_kept_after_wr", bus.line_rdata_o, l1);
    burst(0, 1, 32'h0000_4040, '0, l3, 16'h0059, 8, "rdws");
    burst(1, 0, 32'h1234_567F, wline, '0, 16'h001B, 6, "wrback");
    chk("rdata_kept_after_wrback", bus.line_rdata_o, l3);
    burst(1, 1, 32'h0000_0020, l4, '0, 16'hFFFF, 5, "both");

    // Reset two beats into a read.
    bus.line_read_i = 1'b1;
    bus.line_addr_i = 32'h0000_9000;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      bus.mem_resp_i  = 1'b1;
      bus.mem_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    bus.mem_resp_i  = 1'b0;
    bus.line_read_i = 1'b0;
    @(posedge clk); #1;
    chk("midrst_read", bus.mem_read_o, 1'b0);
    chk("midrst_resp", bus.line_resp_o, 1'b0);
    chk("midrst_rdata", bus.line_rdata_o, 0);
    chk("midrst_addr", bus.mem_addr_o, 0);
    rst = 1'b0;
    cur_rdata = '0;
    @(posedge clk); #1;
    burst(0, 1, 32'h0000_A0E7, '0, l4, 16'hFFFF, 5, "rd_after_rst");

    repeat (3) @(posedge clk);
    #1;
    chk("wbeat_q_empty", wbeat_q.size(), 0);
    chk("resp_q_empty", resp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/line_burst_adapter.md
Name: line_burst_adapter

Overview:
- Memory-side responder for the cache controller's downstream port: it accepts a 256-bit line read or write from a cache and answers with a single-cycle resp.
- Toward physical memory it acts as a burst initiator, moving the line as 4 consecutive 64-bit beats.
- It sits between the L1/L2 cache downstream ports (or the arbiter) and the burst memory model / DRAM interface.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BEAT_WIDTH, 64, memory burst beat width in bits.
- ADDR_WIDTH, 32, byte address width.
- BEATS, LINE_WIDTH/BEAT_WIDTH (=4), beats per line; derived, not overridable.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- line_read_i  in  1  cache requests a line fill; held until line_resp_o.
- line_write_i  in  1  cache requests a line writeback; held until line_resp_o.
- line_addr_i  in  ADDR_WIDTH  line byte address (low 5 bits ignored).
- line_wdata_i  in  LINE_WIDTH  line to write; beat k = bits [64k+63:64k].
- line_rdata_o  out  LINE_WIDTH  assembled fill line; valid while line_resp_o=1, held until the next fill completes.
- line_resp_o  out  1  one-cycle completion pulse to the cache.
- mem_addr_o  out  ADDR_WIDTH  latched line address with low 5 bits forced to 0.
- mem_read_o  out  1  burst read request.
- mem_write_o  out  1  burst write request.
- mem_wdata_o  out  BEAT_WIDTH  current write beat.
- mem_rdata_i  in  BEAT_WIDTH  read beat, valid when mem_resp_i=1.
- mem_resp_i  in  1  beat accepted (write) or beat valid (read).

Behaviour:
- Reset values (all registered): state=IDLE, beat count=0, mem_read_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0, line_rdata_o=0, line_resp_o=0.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On line_write_i=1, latch addr and wdata, count=0, go to WRITE.
  - Else on line_read_i=1, latch addr, count=0, go to READ.
  - Both asserted at once is illegal from a cache, but write wins deterministically.
- READ:
  - mem_read_o=1, first asserted the cycle after the request is sampled.
  - Each cycle with mem_resp_i=1: store mem_rdata_i into beat[count], count++.
  - When count==BEATS-1 and mem_resp_i=1, go to DONE.
  - mem_resp_i gaps mid-burst are tolerated: count holds and mem_read_o stays 1.
- WRITE:
  - mem_write_o=1; mem_wdata_o=beat[count] of the latched line, combinational from count.
  - On mem_resp_i, count++.
  - After the BEATS-th accepted beat, go to DONE.
  - Gaps are tolerated as in READ.
- DONE:
  - line_resp_o=1 for exactly one cycle; mem_read_o=mem_write_o=0; next state IDLE unconditionally.
  - For a read, line_rdata_o shows the assembled line.
  - line_rdata_o is not modified by writes.
- Back-to-back: the IDLE cycle after DONE samples requests normally. The cache drops its request the cycle after resp, so no spurious re-trigger occurs.
- Fill-then-writeback: a line_write_i asserted in the IDLE following a read DONE starts immediately.
- Latency with zero-wait memory: request at T, mem_* asserted T+1, beats T+1..T+4, line_resp_o at T+5.
- mem_addr_o is stable for the whole burst; the adapter never reissues mid-burst.
- Request inputs are ignored outside IDLE; address/data changes mid-burst have no effect.
- mem_resp_i outside READ/WRITE is ignored.
- Count is BEATS-wide log2 (2 bits); it never wraps within a burst because the state exits at BEATS-1.
- rst mid-burst: next cycle all outputs return to reset values and the burst is abandoned; memory must tolerate the dropped request.

Decomposition:
- Shared package cache_types holds:
  - LINE_WIDTH, BEAT_WIDTH, BEATS constants;
  - typedef line_t (logic [255:0]);
  - typedef beat_t (logic [63:0]);
  - the adapter state enum.
- The same package is used by the cache datapath.
- No sub-module; the shift/index logic is inlined.

Test Plan:
- Read, zero-wait: line_read_i with addr 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 at T+1..T+4.
  - Required: mem_addr_o=0x0000_1220, line_resp_o exactly at T+5 for 1 cycle, line_rdata_o = {44..,33..,22..,11..}.
- Write: line_wdata_i = {D,C,B,A} at addr 0x8000_00FF.
  - Required: mem_addr_o=0x8000_00E0, mem_wdata_o = A,B,C,D on successive resp cycles, then line_resp_o 1 cycle, mem_write_o=0.
- Wait states: read with mem_resp_i pattern 1,0,0,1,1,0,1.
  - Required: 4 beats assembled in order, mem_read_o held 1 throughout, line_resp_o one cycle after the last beat.
- Fill then writeback: read completes, line_write_i asserted in the following IDLE.
  - Required: mem_write_o asserted the next cycle, line_rdata_o unchanged by the write.
- Simultaneous line_read_i=line_write_i=1.
  - Required: WRITE burst performed, no read issued.
- rst asserted after 2 read beats.
  - Required: next cycle mem_read_o=0, line_resp_o=0, line_rdata_o=0; a fresh read then completes correctly with count starting at 0.
